// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller for the MW pipeline stage.
// Holds mstatus/mie/mip/mtvec/mepc/mcause/mcycle and redirects fetch on trap or mret.
module csr_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_MW,
  input  logic        Stall_MW,
  input  logic        csr_rd_en_MW,
  input  logic        csr_wr_en_MW,
  input  logic        mret_MW,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pc_MW,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        epc_taken,
  output logic [31:0] epc_pc,
  output logic        kill_MW
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE  = 12'hB00;

  localparam logic [4:0] CODE_EXT   = 5'd11;
  localparam logic [4:0] CODE_TIMER = 5'd7;

  logic [SYNC_STAGES-1:0] r_tsync;
  logic [SYNC_STAGES-1:0] r_esync;

  logic        r_mie_bit;
  logic        r_mpie;
  logic        r_mtie;
  logic        r_meie;
  logic [29:0] r_mtvec_base;
  logic        r_mtvec_mode;
  logic [29:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mcycle;

  logic        w_go;
  logic        w_mtip;
  logic        w_meip;
  logic        w_ext;
  logic        w_tmr;
  logic        w_irq;
  logic        w_trap;
  logic        w_mret;
  logic        w_wr;
  logic [4:0]  w_cause_code;
  logic [31:0] w_base;
  logic [31:0] w_vec_off;
  logic [31:0] w_rdata;
  logic [31:0] w_epc_pc;
  logic [31:0] w_mstatus_val;
  logic [31:0] w_mie_val;
  logic [31:0] w_mip_val;
  logic [31:0] w_mtvec_val;
  logic [31:0] w_mepc_val;
  logic        w_unused_pc;

  assign w_unused_pc = ^pc_MW[1:0];

  // Interrupt line synchronisers: shift the raw request through SYNC_STAGES flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tsync <= '0;
      r_esync <= '0;
    end else begin
      r_tsync <= {r_tsync[SYNC_STAGES-2:0], timer_irq};
      r_esync <= {r_esync[SYNC_STAGES-2:0], ext_irq};
    end
  end

  assign w_mtip = r_tsync[SYNC_STAGES-1];
  assign w_meip = r_esync[SYNC_STAGES-1];

  assign w_go   = valid_MW & ~Stall_MW;
  assign w_ext  = r_mie_bit & r_meie & w_meip;
  assign w_tmr  = r_mie_bit & r_mtie & w_mtip;
  assign w_irq  = w_ext | w_tmr;
  assign w_trap = w_go & w_irq;
  assign w_mret = w_go & mret_MW & ~w_irq;
  // A trapped instruction is killed, so its CSR write never lands.
  assign w_wr   = w_go & csr_wr_en_MW & ~w_trap;

  assign w_cause_code  = w_ext ? CODE_EXT : CODE_TIMER;
  assign w_base        = {r_mtvec_base, 2'b00};
  assign w_vec_off     = {25'h000_0000, w_cause_code, 2'b00};

  assign w_mstatus_val = {24'h00_0000, r_mpie, 3'b000, r_mie_bit, 3'b000};
  assign w_mie_val     = {20'h0_0000, r_meie, 3'b000, r_mtie, 7'h00};
  assign w_mip_val     = {20'h0_0000, w_meip, 3'b000, w_mtip, 7'h00};
  assign w_mtvec_val   = {r_mtvec_base, 1'b0, r_mtvec_mode};
  assign w_mepc_val    = {r_mepc, 2'b00};

  // CSR read mux: pre-write value of the addressed register, zero when not reading.
  always_comb begin
    w_rdata = 32'h0000_0000;
    if (csr_rd_en_MW) begin
      case (csr_addr)
        ADDR_MSTATUS: w_rdata = w_mstatus_val;
        ADDR_MIE:     w_rdata = w_mie_val;
        ADDR_MTVEC:   w_rdata = w_mtvec_val;
        ADDR_MEPC:    w_rdata = w_mepc_val;
        ADDR_MCAUSE:  w_rdata = r_mcause;
        ADDR_MIP:     w_rdata = w_mip_val;
        ADDR_MCYCLE:  w_rdata = r_mcycle;
        default:      w_rdata = 32'h0000_0000;
      endcase
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  // Redirect target: trap vector (direct or vectored), mepc on mret, else the trap base.
  always_comb begin
    w_epc_pc = w_base;
    if (w_trap) begin
      if (r_mtvec_mode) begin
        w_epc_pc = w_base + w_vec_off;
      end else begin
        w_epc_pc = w_base;
      end
    end else if (w_mret) begin
      w_epc_pc = w_mepc_val;
    end else begin
      w_epc_pc = w_base;
    end
  end

  assign csr_rdata = w_rdata;
  assign epc_pc    = w_epc_pc;
  assign epc_taken = w_trap | w_mret;
  assign kill_MW   = w_trap;

  // mstatus: trap stacks MIE into MPIE, mret restores it, otherwise CSR write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mie_bit <= 1'b0;
      r_mpie    <= 1'b0;
    end else if (w_trap) begin
      r_mpie    <= r_mie_bit;
      r_mie_bit <= 1'b0;
    end else if (w_mret) begin
      r_mie_bit <= r_mpie;
      r_mpie    <= 1'b1;
    end else if (w_wr && (csr_addr == ADDR_MSTATUS)) begin
      r_mie_bit <= csr_wdata[3];
      r_mpie    <= csr_wdata[7];
    end
  end

  // mie and mtvec change only by CSR write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtie       <= 1'b0;
      r_meie       <= 1'b0;
      r_mtvec_base <= MTVEC_RESET[31:2];
      r_mtvec_mode <= MTVEC_RESET[0];
    end else if (w_wr) begin
      if (csr_addr == ADDR_MIE) begin
        r_mtie <= csr_wdata[7];
        r_meie <= csr_wdata[11];
      end
      if (csr_addr == ADDR_MTVEC) begin
        r_mtvec_base <= csr_wdata[31:2];
        r_mtvec_mode <= csr_wdata[0];
      end
    end
  end

  // mepc/mcause: captured on trap, otherwise loaded by CSR write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mepc   <= 30'h0000_0000;
      r_mcause <= 32'h0000_0000;
    end else if (w_trap) begin
      r_mepc   <= pc_MW[31:2];
      r_mcause <= {1'b1, 26'h000_0000, w_cause_code};
    end else if (w_wr) begin
      if (csr_addr == ADDR_MEPC) begin
        r_mepc <= csr_wdata[31:2];
      end
      if (csr_addr == ADDR_MCAUSE) begin
        r_mcause <= csr_wdata;
      end
    end
  end

  // mcycle: free-running, a CSR write replaces the increment for that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcycle <= 32'h0000_0000;
    end else if (w_wr && (csr_addr == ADDR_MCYCLE)) begin
      r_mcycle <= csr_wdata;
    end else begin
      r_mcycle <= r_mcycle + 32'h0000_0001;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit: CSR access, traps, mret, gating, mcycle, reset.
module tb_csr_unit;

  logic        clk;
  logic        rst;
  logic        valid_MW;
  logic        Stall_MW;
  logic        csr_rd_en_MW;
  logic        csr_wr_en_MW;
  logic        mret_MW;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] pc_MW;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc_pc;
  logic        kill_MW;

  int checks = 0;
  int errors = 0;
  logic [31:0] v;

  csr_unit #(.MTVEC_RESET(32'h0000_0000), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .valid_MW(valid_MW), .Stall_MW(Stall_MW),
    .csr_rd_en_MW(csr_rd_en_MW), .csr_wr_en_MW(csr_wr_en_MW), .mret_MW(mret_MW),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .pc_MW(pc_MW),
    .timer_irq(timer_irq), .ext_irq(ext_irq), .csr_rdata(csr_rdata),
    .epc_taken(epc_taken), .epc_pc(epc_pc), .kill_MW(kill_MW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; the write commits on the following posedge.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    valid_MW = 1'b1; csr_wr_en_MW = 1'b1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    valid_MW = 1'b0; csr_wr_en_MW = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] val);
    csr_rd_en_MW = 1'b1; csr_addr = a;
    #1;
    val = csr_rdata;
    csr_rd_en_MW = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %b want 0", epc_taken); end
    checks++; if (kill_MW !== 1'b0) begin errors++; $display("FAIL rst_kill: got %b want 0", kill_MW); end
    checks++; if (epc_pc !== 32'h0000_0000) begin errors++; $display("FAIL rst_epc_pc: got %h want 00000000", epc_pc); end
    rd(12'h305, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL rst_mtvec: got %h want 00000000", v); end
    rd(12'hB00, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL rst_mcycle: got %h want 00000000", v); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rd(12'hB00, v);
    checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL mcycle_resume: got %h want 00000001", v); end
  endtask

  task automatic test_write_read;
    do_write(12'h305, 32'h0000_1001);
    rd(12'h305, v);
    checks++; if (v !== 32'h0000_1001) begin errors++; $display("FAIL mtvec_rw: got %h want 00001001", v); end
    do_write(12'h305, 32'h0000_1003);
    rd(12'h305, v);
    checks++; if (v !== 32'h0000_1001) begin errors++; $display("FAIL mtvec_bit1: got %h want 00001001", v); end
    do_write(12'h344, 32'hFFFF_FFFF);
    rd(12'h344, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL mip_ro: got %h want 00000000", v); end
    rd(12'h7C0, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL unimpl_rd: got %h want 00000000", v); end
    do_write(12'h341, 32'h1234_5677);
    rd(12'h341, v);
    checks++; if (v !== 32'h1234_5674) begin errors++; $display("FAIL mepc_mask: got %h want 12345674", v); end
    do_write(12'h342, 32'hDEAD_BEEF);
    rd(12'h342, v);
    checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mcause_rw: got %h want deadbeef", v); end
    do_write(12'h304, 32'hFFFF_FFFF);
    rd(12'h304, v);
    checks++; if (v !== 32'h0000_0880) begin errors++; $display("FAIL mie_mask: got %h want 00000880", v); end
    do_write(12'h300, 32'hFFFF_FFFF);
    rd(12'h300, v);
    checks++; if (v !== 32'h0000_0088) begin errors++; $display("FAIL mstatus_mask: got %h want 00000088", v); end
    csr_addr = 12'h300;
    #1;
    checks++; if (csr_rdata !== 32'h0000_0000) begin errors++; $display("FAIL rd_en_low: got %h want 00000000", csr_rdata); end
    do_write(12'h300, 32'h0000_0000);
  endtask

  task automatic test_timer_trap;
    do_write(12'h305, 32'h0000_0100);
    do_write(12'h304, 32'h0000_0080);
    do_write(12'h300, 32'h0000_0008);
    timer_irq = 1'b1; valid_MW = 1'b1; pc_MW = 32'h0000_0040;
    #1;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL tmr_lat0: got %b want 0", epc_taken); end
    @(negedge clk); #1;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL tmr_lat1: got %b want 0", epc_taken); end
    @(negedge clk); #1;
    checks++; if (epc_taken !== 1'b1) begin errors++; $display("FAIL tmr_taken: got %b want 1", epc_taken); end
    checks++; if (epc_pc !== 32'h0000_0100) begin errors++; $display("FAIL tmr_epc_pc: got %h want 00000100", epc_pc); end
    checks++; if (kill_MW !== 1'b1) begin errors++; $display("FAIL tmr_kill: got %b want 1", kill_MW); end
    rd(12'h344, v);
    checks++; if (v !== 32'h0000_0080) begin errors++; $display("FAIL tmr_mip: got %h want 00000080", v); end
    @(negedge clk);
    valid_MW = 1'b0;
    rd(12'h341, v);
    checks++; if (v !== 32'h0000_0040) begin errors++; $display("FAIL tmr_mepc: got %h want 00000040", v); end
    rd(12'h342, v);
    checks++; if (v !== 32'h8000_0007) begin errors++; $display("FAIL tmr_mcause: got %h want 80000007", v); end
    rd(12'h300, v);
    checks++; if (v !== 32'h0000_0080) begin errors++; $display("FAIL tmr_mstatus: got %h want 00000080", v); end
    timer_irq = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mret;
    valid_MW = 1'b1; mret_MW = 1'b1; pc_MW = 32'h0000_0060;
    #1;
    checks++; if (epc_taken !== 1'b1) begin errors++; $display("FAIL mret_taken: got %b want 1", epc_taken); end
    checks++; if (epc_pc !== 32'h0000_0040) begin errors++; $display("FAIL mret_epc_pc: got %h want 00000040", epc_pc); end
    checks++; if (kill_MW !== 1'b0) begin errors++; $display("FAIL mret_kill: got %b want 0", kill_MW); end
    @(negedge clk);
    valid_MW = 1'b0; mret_MW = 1'b0;
    rd(12'h300, v);
    checks++; if (v !== 32'h0000_0088) begin errors++; $display("FAIL mret_mstatus: got %h want 00000088", v); end
  endtask

  task automatic test_vectored;
    do_write(12'h305, 32'h0000_0201);
    do_write(12'h304, 32'h0000_0880);
    timer_irq = 1'b1; ext_irq = 1'b1;
    repeat (2) @(negedge clk);
    valid_MW = 1'b1; pc_MW = 32'h0000_0080;
    #1;
    checks++; if (epc_taken !== 1'b1) begin errors++; $display("FAIL vec_taken: got %b want 1", epc_taken); end
    checks++; if (epc_pc !== 32'h0000_022C) begin errors++; $display("FAIL vec_epc_pc: got %h want 0000022c", epc_pc); end
    checks++; if (kill_MW !== 1'b1) begin errors++; $display("FAIL vec_kill: got %b want 1", kill_MW); end
    @(negedge clk);
    valid_MW = 1'b0;
    rd(12'h342, v);
    checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL vec_mcause: got %h want 8000000b", v); end
    rd(12'h341, v);
    checks++; if (v !== 32'h0000_0080) begin errors++; $display("FAIL vec_mepc: got %h want 00000080", v); end
    rd(12'h300, v);
    checks++; if (v !== 32'h0000_0080) begin errors++; $display("FAIL vec_mstatus: got %h want 00000080", v); end
    timer_irq = 1'b0; ext_irq = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_gating;
    do_write(12'h305, 32'h0000_0100);
    do_write(12'h304, 32'h0000_0080);
    timer_irq = 1'b1;
    repeat (3) @(negedge clk);
    do_write(12'h300, 32'h0000_0008);
    valid_MW = 1'b1; Stall_MW = 1'b1; csr_wr_en_MW = 1'b1;
    csr_addr = 12'h342; csr_wdata = 32'h0000_1234; pc_MW = 32'h0000_00C6;
    #1;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL stall_taken: got %b want 0", epc_taken); end
    checks++; if (kill_MW !== 1'b0) begin errors++; $display("FAIL stall_kill: got %b want 0", kill_MW); end
    @(negedge clk);
    valid_MW = 1'b0; Stall_MW = 1'b0;
    #1;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL invalid_taken: got %b want 0", epc_taken); end
    checks++; if (kill_MW !== 1'b0) begin errors++; $display("FAIL invalid_kill: got %b want 0", kill_MW); end
    @(negedge clk);
    csr_wr_en_MW = 1'b0;
    rd(12'h342, v);
    checks++; if (v !== 32'h8000_000B) begin errors++; $display("FAIL gated_mcause: got %h want 8000000b", v); end
    rd(12'h300, v);
    checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL gated_mstatus: got %h want 00000008", v); end
    valid_MW = 1'b1; csr_wr_en_MW = 1'b1; csr_addr = 12'h342; csr_wdata = 32'h0000_1234;
    #1;
    checks++; if (epc_taken !== 1'b1) begin errors++; $display("FAIL go_taken: got %b want 1", epc_taken); end
    checks++; if (kill_MW !== 1'b1) begin errors++; $display("FAIL go_kill: got %b want 1", kill_MW); end
    checks++; if (epc_pc !== 32'h0000_0100) begin errors++; $display("FAIL go_epc_pc: got %h want 00000100", epc_pc); end
    @(negedge clk);
    valid_MW = 1'b0; csr_wr_en_MW = 1'b0;
    rd(12'h342, v);
    checks++; if (v !== 32'h8000_0007) begin errors++; $display("FAIL drop_write: got %h want 80000007", v); end
    rd(12'h341, v);
    checks++; if (v !== 32'h0000_00C4) begin errors++; $display("FAIL go_mepc: got %h want 000000c4", v); end
    timer_irq = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mcycle;
    do_write(12'hB00, 32'hFFFF_FFFE);
    rd(12'hB00, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mcycle_0: got %h want fffffffe", v); end
    @(negedge clk);
    rd(12'hB00, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mcycle_1: got %h want ffffffff", v); end
    @(negedge clk);
    rd(12'hB00, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL mcycle_wrap: got %h want 00000000", v); end
  endtask

  task automatic test_reset_mid_trap;
    do_write(12'h305, 32'h0000_0300);
    do_write(12'h304, 32'h0000_0800);
    do_write(12'h300, 32'h0000_0008);
    ext_irq = 1'b1;
    repeat (2) @(negedge clk);
    valid_MW = 1'b1; pc_MW = 32'h0000_0010;
    #1;
    checks++; if (epc_taken !== 1'b1) begin errors++; $display("FAIL pre_rst_taken: got %b want 1", epc_taken); end
    rst = 1'b0;
    #1;
    checks++; if (epc_taken !== 1'b0) begin errors++; $display("FAIL mid_rst_taken: got %b want 0", epc_taken); end
    checks++; if (kill_MW !== 1'b0) begin errors++; $display("FAIL mid_rst_kill: got %b want 0", kill_MW); end
    checks++; if (epc_pc !== 32'h0000_0000) begin errors++; $display("FAIL mid_rst_epc_pc: got %h want 00000000", epc_pc); end
    rd(12'h300, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL mid_rst_mstatus: got %h want 00000000", v); end
    rd(12'h305, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL mid_rst_mtvec: got %h want 00000000", v); end
    @(negedge clk);
    valid_MW = 1'b0; ext_irq = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rd(12'hB00, v);
    checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL post_rst_mcycle: got %h want 00000001", v); end
    rd(12'h304, v);
    checks++; if (v !== 32'h0000_0000) begin errors++; $display("FAIL post_rst_mie: got %h want 00000000", v); end
  endtask

  initial begin
    valid_MW = 1'b0; Stall_MW = 1'b0; csr_rd_en_MW = 1'b0; csr_wr_en_MW = 1'b0;
    mret_MW = 1'b0; csr_addr = 12'h000; csr_wdata = 32'h0000_0000;
    pc_MW = 32'h0000_0000; timer_irq = 1'b0; ext_irq = 1'b0; rst = 1'b0;
    test_reset;
    test_write_read;
    test_timer_trap;
    test_mret;
    test_vectored;
    test_gating;
    test_mcycle;
    test_reset_mid_trap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
# csr_unit

Machine-mode CSR file and trap controller for the Memory/Writeback (MW) stage of the pipeline. It consumes the registered CSR control bits (csr_rd_en_MW, csr_wr_en_MW, mret_MW) and the MW-stage instruction context, holds mstatus/mie/mip/mtvec/mepc/mcause/mcycle, and synchronises the timer and external interrupt lines. When it takes a trap or an mret, it issues a PC redirect and kills the MW instruction.

## Interface
- MTVEC_RESET, 32'h0000_0000, reset value of mtvec
- SYNC_STAGES, 2, flop depth of each interrupt synchroniser (minimum 2)

- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- valid_MW  input  1  MW stage holds a real instruction
- Stall_MW  input  1  MW stage held this cycle
- csr_rd_en_MW  input  1  instruction reads a CSR
- csr_wr_en_MW  input  1  instruction writes a CSR
- mret_MW  input  1  instruction is mret
- csr_addr  input  12  CSR address
- csr_wdata  input  32  write data (forwarded rs1)
- pc_MW  input  32  PC of the MW instruction
- timer_irq  input  1  async machine timer interrupt request
- ext_irq  input  1  async machine external interrupt request
- csr_rdata  output  32  read data, combinational
- epc_taken  output  1  redirect the fetch PC this cycle
- epc_pc  output  32  redirect target
- kill_MW  output  1  suppress RegWrite/wr_en of the MW instruction

## Operation
- Commit condition: `go = valid_MW & ~Stall_MW`.
- Implemented CSRs and writable bits:
  - mstatus 0x300: MIE bit3, MPIE bit7 writable; all other bits read 0.
  - mie 0x304: MTIE bit7, MEIE bit11 writable.
  - mtvec 0x305: bits[31:2] and bit0 (mode) writable; bit1 reads 0.
  - mepc 0x341: bits[31:2] writable; bits[1:0] read 0.
  - mcause 0x342: all 32 bits writable.
  - mip 0x344: read-only. MTIP bit7 and MEIP bit11 are the synchronised irq lines; writes are ignored.
  - mcycle 0xB00: 32-bit free-running counter, +1 every cycle including stalls, wraps from FFFF_FFFF to 0. A CSR write loads csr_wdata, with no increment that cycle.
- Read: csr_rdata = current (pre-write) value of the addressed CSR. Unimplemented address reads 0. csr_rdata is 0 when csr_rd_en_MW = 0.
- Write: full-word replace (CSRRW) at the next posedge when `go & csr_wr_en_MW & ~kill_MW`. Unimplemented addresses are ignored.
- Interrupt pending: `irq = mstatus.MIE & ((mie.MEIE & mip.MEIP) | (mie.MTIE & mip.MTIP))`. External has priority over timer.
- Trap when `go & irq`:
  - kill_MW = 1, epc_taken = 1.
  - mepc <= {pc_MW[31:2], 2'b00}.
  - mcause <= 32'h8000_000B for external, 32'h8000_0007 for timer.
  - MPIE <= MIE, MIE <= 0.
  - epc_pc = {mtvec[31:2], 2'b00} when mode = 0; otherwise that base + 4 × cause code (0x2C external, 0x1C timer).
- mret when `go & mret_MW & ~irq`:
  - epc_taken = 1, kill_MW = 0, epc_pc = mepc.
  - MIE <= MPIE, MPIE <= 1.
- A trap has priority over mret and over a CSR write in the same cycle; the killed instruction's write is dropped.
- When go = 0: no trap, no mret effect, no CSR write. epc_taken = 0, kill_MW = 0.

## Timing
- epc_taken, epc_pc, kill_MW and csr_rdata are combinational, valid in the same cycle the condition holds.
- CSR state updates on the following posedge. A back-to-back read of a just-written CSR returns the new value.
- Interrupt latency from an irq line edge to visibility in mip is SYNC_STAGES cycles. A trap can be taken in the first subsequent cycle with go = 1.
- Reset (rst = 0, async, any cycle including mid-trap): all CSRs are 0 except mtvec = MTVEC_RESET; mcycle = 0; synchronisers are 0. Outputs therefore read epc_taken = 0, kill_MW = 0, csr_rdata = 0, and epc_pc = MTVEC_RESET with bits[1:0] cleared. Counting resumes on the first posedge after release.
- Holding an irq while MIE = 0 causes no trap. Setting MIE by CSR write traps on the next go cycle.

## Test plan
- Write/read: CSRRW mtvec ← 0x0000_1001, then read → 0x0000_1001. Write mip ← FFFF_FFFF, then read mip → 0 (irqs low). Read 0x7C0 → 0.
- Timer trap, direct: mtvec = 0x100, mie = 0x80, mstatus = 0x8. Raise timer_irq at pc_MW = 0x40 → after 2 cycles epc_taken = 1, epc_pc = 0x100, kill_MW = 1. Next cycle mepc = 0x40, mcause = 8000_0007, mstatus = 0x80.
- Vectored with priority: mtvec = 0x201, both irqs enabled and raised → epc_pc = 0x22C, mcause = 8000_000B.
- mret: with mepc = 0x40 and MPIE = 1 → epc_pc = 0x40, kill_MW = 0. Next cycle mstatus = 0x88.
- Stall/valid gating: irq pending while Stall_MW = 1 or valid_MW = 0 → no epc_taken and no CSR change; the trap fires on the first go cycle. A CSR write in the trap cycle is dropped.
- mcycle and reset: write mcycle ← FFFF_FFFE → reads FFFF_FFFE, FFFF_FFFF, 0 on successive cycles. Assert rst mid-trap → all outputs/CSRs at reset values immediately, without waiting for a clock edge.
